// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: conditions raw ps2_clk/ps2_data, deframes device-to-host bytes, strips F0/E0 prefixes.
// Optional macro PS2_PARITY_CHK_EN adds odd-parity checking and the err pulse; without it err is tied 0.
module ps2_scan_receiver #(
    parameter int          FILT    = 4,
    parameter int          TIMEOUT = 50000,
    parameter logic [7:0]  KEY_UP  = 8'h73,
    parameter logic [7:0]  KEY_DN  = 8'h72
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] Cambio,
    output logic       got_data,
    output logic [7:0] estado,
    output logic       extended,
    output logic       err
);

    // state | meaning
    // IDLE  | waiting for a start bit (fe with data low)
    // RECV  | shifting data, parity and stop bits; watchdog armed
    // CHECK | one cycle: validate frame, handle prefixes, publish make code
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [3:0]     FILT_LOAD = 4'(FILT - 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic          fe;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          stop_q, stop_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    cambio_q, cambio_d;
    logic [7:0]    estado_q, estado_d;
    logic          extended_q, extended_d;
    logic          got_data_q, got_data_d;
    logic          frame_ok;
`ifdef PS2_PARITY_CHK_EN
    logic          par_q, par_d;
    logic          err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered level flips once the synced line has differed for FILT consecutive cycles.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = FILT_LOAD;
        fe     = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == 4'd0) begin
                filt_d = clk_s2_q;
                fe     = filt_q;
            end else begin
                fcnt_d = fcnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q <= 1'b1;
            fcnt_q <= FILT_LOAD;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

`ifdef PS2_PARITY_CHK_EN
    assign frame_ok = stop_q & (^{par_q, data_q});
`else
    assign frame_ok = stop_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        stop_d     = stop_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        cambio_d   = cambio_q;
        estado_d   = estado_q;
        extended_d = extended_q;
        got_data_d = 1'b0;
`ifdef PS2_PARITY_CHK_EN
        par_d      = par_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                tmo_d = '0;
                if (fe && !dat_s2_q) begin
                    state_d = RECV;
                    cnt_d   = 4'd1;
                    tmo_d   = TMO_LOAD;
                end
            end
            RECV: begin
                if (fe) begin
                    cnt_d = cnt_q + 4'd1;
                    tmo_d = TMO_LOAD;
                    if (cnt_q == 4'd10) begin
                        stop_d  = dat_s2_q;
                        state_d = CHECK;
                    end else if (cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHK_EN
                        par_d = dat_s2_q;
`endif
                    end else begin
                        data_d = {dat_s2_q, data_q[7:1]};
                    end
                end else if (tmo_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                tmo_d   = '0;
                if (frame_ok) begin
                    if (data_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (data_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (brk_q) begin
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        cambio_d   = data_q;
                        extended_d = ext_q;
                        ext_d      = 1'b0;
                        got_data_d = 1'b1;
                        // Adjust keys drive the counters only; mode byte keeps the last real key.
                        if (data_q != KEY_UP && data_q != KEY_DN) begin
                            estado_d = data_q;
                        end
                    end
                end else begin
`ifdef PS2_PARITY_CHK_EN
                    err_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            tmo_q      <= '0;
            data_q     <= 8'h00;
            stop_q     <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            cambio_q   <= 8'h00;
            estado_q   <= 8'h00;
            extended_q <= 1'b0;
            got_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            stop_q     <= stop_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            cambio_q   <= cambio_d;
            estado_q   <= estado_d;
            extended_q <= extended_d;
            got_data_q <= got_data_d;
        end
    end

`ifdef PS2_PARITY_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign Cambio   = cambio_q;
    assign got_data = got_data_q;
    assign estado   = estado_q;
    assign extended = extended_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: bit-banged PS/2 frames, strobe/err counting, immediate-assertion checks.
module tb_ps2_scan_receiver;

    localparam int FILT    = 4;
    localparam int TIMEOUT = 100;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] Cambio;
    logic       got_data;
    logic [7:0] estado;
    logic       extended;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int gd_count  = 0;
    int err_count = 0;
    int gd_cyc    = -1;
    int stop_mark = 0;

    ps2_scan_receiver #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT),
        .KEY_UP  (8'h73),
        .KEY_DN  (8'h72)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .Cambio   (Cambio),
        .got_data (got_data),
        .estado   (estado),
        .extended (extended),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (got_data === 1'b1) begin
            gd_count = gd_count + 1;
            gd_cyc   = cyc;
        end
        if (err === 1'b1) err_count = err_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits bits of an 11-bit frame; all line changes happen on negedges.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch && i == 5) begin
                repeat (4) @(negedge clk);
                ps2_clk = 1'b0;
                @(negedge clk);
                ps2_clk = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_mark = cyc;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 11);
    endtask

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cambio",   32'(Cambio),   32'h00);
        check("rst_estado",   32'(estado),   32'h00);
        check("rst_got_data", 32'(got_data), 32'h0);
        check("rst_extended", 32'(extended), 32'h0);
        check("rst_err",      32'(err),      32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'h75);
        check("m75_count",   gd_count,              1);
        check("m75_latency", gd_cyc - stop_mark,    FILT + 3);
        check("m75_cambio",  32'(Cambio),           32'h75);
        check("m75_estado",  32'(estado),           32'h75);
        check("m75_ext",     32'(extended),         32'h0);
        check("idle_gd_low", 32'(got_data),         32'h0);

        send_byte(8'h6C);
        check("m6c_count",  gd_count,    2);
        check("m6c_estado", 32'(estado), 32'h6C);

        send_byte(8'h73);
        check("up_count",  gd_count,    3);
        check("up_cambio", 32'(Cambio), 32'h73);
        check("up_estado", 32'(estado), 32'h6C);

        send_byte(8'h72);
        check("dn_count",  gd_count,    4);
        check("dn_cambio", 32'(Cambio), 32'h72);
        check("dn_estado", 32'(estado), 32'h6C);

        send_byte(8'hF0);
        send_byte(8'h72);
        check("rel_count",  gd_count,    4);
        check("rel_cambio", 32'(Cambio), 32'h72);
        check("rel_estado", 32'(estado), 32'h6C);

        send_byte(8'hE0);
        send_byte(8'h75);
        check("e0_count",  gd_count,      5);
        check("e0_cambio", 32'(Cambio),   32'h75);
        check("e0_ext",    32'(extended), 32'h1);
        check("e0_estado", 32'(estado),   32'h75);

        send_byte(8'h72);
        check("after_e0_count", gd_count,      6);
        check("after_e0_ext",   32'(extended), 32'h0);

        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("xrel_count", gd_count, 6);
        send_byte(8'h6C);
        check("xrel_next_count",  gd_count,      7);
        check("xrel_next_ext",    32'(extended), 32'h0);
        check("xrel_next_estado", 32'(estado),   32'h6C);

        send_byte(8'h6C);
        send_byte(8'h6C);
        check("typematic_count", gd_count, 9);

        send_frame(8'h75, 1'b0, 1'b0, 1'b0, 8);
        repeat (TIMEOUT + 50) @(negedge clk);
        send_byte(8'h73);
        check("tmo_count",  gd_count,    10);
        check("tmo_cambio", 32'(Cambio), 32'h73);

        send_frame(8'h75, 1'b0, 1'b0, 1'b1, 11);
        check("glitch_count",  gd_count,    11);
        check("glitch_cambio", 32'(Cambio), 32'h75);

        send_frame(8'h6C, 1'b0, 1'b1, 1'b0, 11);
        check("badstop_count",  gd_count,    11);
        check("badstop_cambio", 32'(Cambio), 32'h75);

        send_byte(8'h6C);
        check("pre_par_count", gd_count, 12);
        send_frame(8'h75, 1'b1, 1'b0, 1'b0, 11);
`ifdef PS2_PARITY_CHK_EN
        check("par_count",  gd_count,    12);
        check("par_cambio", 32'(Cambio), 32'h6C);
        check("par_err",    err_count,   2);
`else
        check("par_count",  gd_count,    13);
        check("par_cambio", 32'(Cambio), 32'h75);
        check("par_err",    err_count,   0);
`endif

        send_frame(8'h6C, 1'b0, 1'b0, 1'b0, 5);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_cambio", 32'(Cambio), 32'h00);
        check("midrst_estado", 32'(estado), 32'h00);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        gd_count = 0;
        send_byte(8'h75);
        check("postrst_count",  gd_count,    1);
        check("postrst_cambio", 32'(Cambio), 32'h75);
        check("postrst_estado", 32'(estado), 32'h75);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
